// File: rtl/comp_arbiter_pkg.sv
// Shared constants, state encoding and condition decode for the comparator arbiter.
package comp_arbiter_pkg;

  localparam logic [2:0] COND_EQ  = 3'b000;
  localparam logic [2:0] COND_NE  = 3'b001;
  localparam logic [2:0] COND_LT  = 3'b100;
  localparam logic [2:0] COND_GE  = 3'b101;
  localparam logic [2:0] COND_LTU = 3'b110;
  localparam logic [2:0] COND_GEU = 3'b111;

  localparam logic REQ_BRANCH = 1'b0;
  localparam logic REQ_ALU    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

  // Reserved codes (010/011) yield 0; the branch unit can reuse this decode.
  function automatic logic cond_decode(input logic [2:0] op, input logic zero,
                                       input logic slt, input logic sltu);
    case (op)
      COND_EQ:  cond_decode = zero;
      COND_NE:  cond_decode = !zero;
      COND_LT:  cond_decode = slt;
      COND_GE:  cond_decode = !slt;
      COND_LTU: cond_decode = sltu;
      COND_GEU: cond_decode = !sltu;
      default:  cond_decode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/comp_arbiter_if.sv
// Request/response bundle between the two requesters and the comparator arbiter.
interface comp_arbiter_if #(
  parameter int DW  = 32,
  parameter int OPW = 3
);
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [DW-1:0]  req0_data1;
  logic [DW-1:0]  req0_data2;
  logic [OPW-1:0] req0_op;
  logic [DW-1:0]  req1_data1;
  logic [DW-1:0]  req1_data2;
  logic [OPW-1:0] req1_op;
  logic [1:0]     resp_valid;
  logic [1:0]     resp_ready;
  logic           resp_result;
  logic [2:0]     resp_flags;

  modport master (
    output req_valid, req0_data1, req0_data2, req0_op,
           req1_data1, req1_data2, req1_op, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_flags
  );

  modport slave (
    input  req_valid, req0_data1, req0_data2, req0_op,
           req1_data1, req1_data2, req1_op, resp_ready,
    output req_ready, resp_valid, resp_result, resp_flags
  );
endinterface

// File: rtl/comp.sv
// Shared combinational comparator: equality, signed and unsigned less-than flags.
module comp #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] data1,
  input  logic [DW-1:0] data2,
  output logic          zero,
  output logic          slt,
  output logic          sltu
);
  assign zero = (data1 == data2);
  assign slt  = ($signed(data1) < $signed(data2));
  assign sltu = (data1 < data2);
endmodule

// File: rtl/comp_arbiter.sv
// Round-robin arbiter sharing one comparator between the branch unit and the ALU,
// with a single registered response slot that can drain and refill in one cycle.
module comp_arbiter
  import comp_arbiter_pkg::*;
#(
  parameter int DW  = 32,
  parameter int OPW = 3
) (
  input logic          clk,
  input logic          rst_n,
  comp_arbiter_if.slave bus
);

  slot_state_t    state;
  logic           owner;
  logic           last_grant;
  logic           result_q;
  logic [2:0]     flags_q;

  logic [1:0]     grant;
  logic           gsel;
  logic           drain;
  logic           can_accept;
  logic           accept;
  logic [DW-1:0]  opa;
  logic [DW-1:0]  opb;
  logic [OPW-1:0] op;
  logic           zero;
  logic           slt;
  logic           sltu;

  always_comb begin
    grant = '0;
    case (bus.req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == REQ_ALU) ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  assign gsel       = grant[1];
  assign drain      = (state == ST_FULL) && bus.resp_ready[owner];
  assign can_accept = (state == ST_EMPTY) || drain;
  // rst_n gating keeps req_ready low while reset is held.
  assign bus.req_ready = grant & {2{can_accept & rst_n}};
  assign accept        = |bus.req_ready;

  assign opa = (gsel == REQ_ALU) ? bus.req1_data1 : bus.req0_data1;
  assign opb = (gsel == REQ_ALU) ? bus.req1_data2 : bus.req0_data2;
  assign op  = (gsel == REQ_ALU) ? bus.req1_op    : bus.req0_op;

  comp #(.DW(DW)) u_comp (
    .data1 (opa),
    .data2 (opb),
    .zero  (zero),
    .slt   (slt),
    .sltu  (sltu)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      owner      <= REQ_BRANCH;
      last_grant <= REQ_ALU;
      result_q   <= 1'b0;
      flags_q    <= '0;
    end else if (accept) begin
      state      <= ST_FULL;
      owner      <= gsel;
      last_grant <= gsel;
      result_q   <= cond_decode(op[2:0], zero, slt, sltu);
      flags_q    <= {zero, slt, sltu};
    end else if (drain) begin
      state <= ST_EMPTY;
    end
  end

  assign bus.resp_valid  = (state == ST_FULL) ? ((owner == REQ_ALU) ? 2'b10 : 2'b01) : 2'b00;
  assign bus.resp_result = result_q;
  assign bus.resp_flags  = flags_q;

endmodule

// File: tb/tb_comp_arbiter.sv
// Randomized and directed bench for comp_arbiter against a behavioural slot model.
module tb_comp_arbiter;
  import comp_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  comp_arbiter_if #(.DW(32), .OPW(3)) bus ();

  comp_arbiter #(.DW(32), .OPW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: one result slot plus the id of the last winner.
  bit       m_full;
  bit       m_owner;
  bit       m_last;
  bit       m_result;
  bit [2:0] m_flags;
  logic [1:0] last_ready;

  function automatic bit ref_result(input bit [2:0] o, input bit [31:0] a, input bit [31:0] b);
    int sa = a;
    int sb = b;
    case (o)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit [2:0] ref_flags(input bit [31:0] a, input bit [31:0] b);
    int sa = a;
    int sb = b;
    return {a == b, sa < sb, a < b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_owner = 0; m_last = 1; m_result = 0; m_flags = '0;
  endtask

  task automatic check_resp();
    chk("resp_valid", bus.resp_valid, m_full ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
    if (m_full) begin
      chk("resp_result", bus.resp_result, m_result);
      chk("resp_flags", bus.resp_flags, m_flags);
    end
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic cycle(input logic [1:0] v,
                       input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] o0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] o1,
                       input logic [1:0] rr);
    logic [1:0] g;
    logic [1:0] exp_ready;
    bus.req_valid = v;
    bus.req0_data1 = a0; bus.req0_data2 = b0; bus.req0_op = o0;
    bus.req1_data1 = a1; bus.req1_data2 = b1; bus.req1_op = o1;
    bus.resp_ready = rr;
    #1;
    if (v == 2'b11) g = m_last ? 2'b01 : 2'b10;
    else            g = v;
    exp_ready = (!m_full || rr[m_owner]) ? g : 2'b00;
    chk("req_ready", bus.req_ready, exp_ready);
    @(posedge clk);
    if (exp_ready == 2'b01) begin
      m_full = 1; m_owner = 0; m_last = 0;
      m_result = ref_result(o0, a0, b0); m_flags = ref_flags(a0, b0);
    end else if (exp_ready == 2'b10) begin
      m_full = 1; m_owner = 1; m_last = 1;
      m_result = ref_result(o1, a1, b1); m_flags = ref_flags(a1, b1);
    end else if (m_full && rr[m_owner]) begin
      m_full = 0;
    end
    #1;
    check_resp();
    last_ready = exp_ready;
  endtask

  task automatic idle(input logic [1:0] rr);
    cycle(2'b00, '0, '0, 3'd0, '0, '0, 3'd0, rr);
  endtask

  // Asserts reset mid-cycle and releases it two edges later.
  task automatic mid_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_resp_valid", bus.resp_valid, 2'b00);
    chk("rst_resp_result", bus.resp_result, 1'b0);
    chk("rst_resp_flags", bus.resp_flags, 3'b000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  v;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  o0, o1;

    model_reset();
    last_ready = '0;
    bus.req_valid = 2'b11;
    bus.resp_ready = 2'b11;
    bus.req0_data1 = '0; bus.req0_data2 = '0; bus.req0_op = '0;
    bus.req1_data1 = '0; bus.req1_data2 = '0; bus.req1_op = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mid_reset();

    // Equality after reset: requester 0 gets the slot.
    cycle(2'b01, 32'd5, 32'd5, COND_EQ, '0, '0, 3'd0, 2'b11);
    chk("eq_ready", last_ready, 2'b01);
    chk("eq_valid", bus.resp_valid, 2'b01);
    chk("eq_result", bus.resp_result, 1'b1);
    chk("eq_flags", bus.resp_flags, 3'b100);

    // Signed vs unsigned on requester 1.
    cycle(2'b10, '0, '0, 3'd0, 32'hFFFF_FFFF, 32'd1, COND_LT, 2'b11);
    chk("lt_result", bus.resp_result, 1'b1);
    cycle(2'b10, '0, '0, 3'd0, 32'hFFFF_FFFF, 32'd1, COND_LTU, 2'b11);
    chk("ltu_result", bus.resp_result, 1'b0);
    cycle(2'b10, '0, '0, 3'd0, 32'hFFFF_FFFF, 32'd1, COND_GEU, 2'b11);
    chk("geu_result", bus.resp_result, 1'b1);
    idle(2'b11);

    // Contention: grants alternate starting with requester 0.
    for (int unsigned i = 0; i < 8; i++) begin
      cycle(2'b11, $urandom, $urandom, 3'($urandom_range(0, 7)),
            $urandom, $urandom, 3'($urandom_range(0, 7)), 2'b11);
      chk("rr_valid", bus.resp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    idle(2'b11);

    // Backpressure on a pending requester 0 result.
    cycle(2'b01, 32'd3, 32'd9, COND_LTU, '0, '0, 3'd0, 2'b00);
    for (int unsigned i = 0; i < 3; i++) begin
      cycle(2'b10, '0, '0, 3'd0, 32'd4, 32'd4, COND_NE, 2'b00);
      chk("bp_ready", last_ready, 2'b00);
      chk("bp_result", bus.resp_result, 1'b1);
      chk("bp_flags", bus.resp_flags, 3'b011);
    end
    cycle(2'b10, '0, '0, 3'd0, 32'd4, 32'd4, COND_NE, 2'b01);
    chk("bp_release_ready", last_ready, 2'b10);
    chk("bp_release_valid", bus.resp_valid, 2'b10);
    chk("bp_release_result", bus.resp_result, 1'b0);
    idle(2'b11);

    // Ready on the non-owner bit must not drain the slot.
    cycle(2'b01, 32'd1, 32'd2, COND_GE, '0, '0, 3'd0, 2'b00);
    idle(2'b10);
    chk("nonowner_valid", bus.resp_valid, 2'b01);
    idle(2'b10);
    chk("nonowner_valid2", bus.resp_valid, 2'b01);
    idle(2'b01);

    // Reserved condition still reports flags.
    cycle(2'b01, 32'd7, 32'd7, 3'b010, '0, '0, 3'd0, 2'b00);
    chk("rsv_result", bus.resp_result, 1'b0);
    chk("rsv_flags", bus.resp_flags, 3'b100);

    // Reset while full discards the pending result.
    mid_reset();
    for (int unsigned i = 0; i < 3; i++) begin
      idle(2'b00);
      chk("post_rst_valid", bus.resp_valid, 2'b00);
    end

    // Random traffic; a stalled requester holds its valid and operands.
    v = 2'b00;
    a0 = '0; b0 = '0; o0 = '0; a1 = '0; b1 = '0; o1 = '0;
    for (int unsigned i = 0; i < 300; i++) begin
      if (!(v[0] && !last_ready[0])) begin
        v[0] = 1'($urandom_range(0, 1));
        a0 = ($urandom_range(0, 3) == 0) ? b0 : $urandom;
        b0 = $urandom; o0 = 3'($urandom_range(0, 7));
      end
      if (!(v[1] && !last_ready[1])) begin
        v[1] = 1'($urandom_range(0, 1));
        a1 = ($urandom_range(0, 3) == 0) ? b1 : $urandom;
        b1 = $urandom; o1 = 3'($urandom_range(0, 7));
      end
      cycle(v, a0, b0, o0, a1, b1, o1, 2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
